// File: rtl/sata_cmd_sequencer.sv
// sata_cmd_sequencer: sends one ATA command as H2D/Data FISes, then collects the D2H status or times out
module sata_cmd_sequencer #(
   parameter int SECTOR_WORDS   = 4,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int LGTIMEOUT      = 13
) (
   input  logic        i_tx_clk,
   input  logic        i_reset,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic [7:0]  i_req_cmd,
   input  logic [27:0] i_req_lba,
   input  logic [7:0]  i_req_count,
   input  logic        i_abort,
   input  logic        i_wr_valid,
   output logic        o_wr_ready,
   input  logic [31:0] i_wr_data,
   output logic        o_s_valid,
   input  logic        i_s_full,
   output logic [31:0] o_s_data,
   output logic        o_s_last,
   output logic        o_s_abort,
   input  logic        i_m_valid,
   output logic        o_m_ready,
   input  logic [31:0] i_m_data,
   input  logic        i_m_last,
   output logic        o_done,
   output logic        o_err,
   output logic        o_timeout,
   output logic [7:0]  o_status,
   output logic [7:0]  o_error
);
   localparam int NWB = $clog2(256 * SECTOR_WORDS + 1);
   localparam int NW  = NWB > 16 ? NWB : 16;
   typedef enum logic [2:0] {IDLE, CMD, DHDR, DATA, ABRT, WAIT_RSP, DONE} state_t;
   state_t               state_q, state_d;
   logic [7:0]           cmd_q, cmd_d, count_q, count_d, status_q, status_d, error_q, error_d;
   logic [27:0]          lba_q, lba_d;
   logic [1:0]           widx_q, widx_d;
   logic [NW-1:0]        wcnt_q, wcnt_d, nwords;
   logic [LGTIMEOUT-1:0] tcnt_q, tcnt_d;
   logic                 timeout_q, timeout_d, abort_q, abort_d, inframe_q, inframe_d, good_q, good_d;
   logic                 wr_class, tx_go, rx_go, rx_good, tx_phase, unused_ok;
   assign unused_ok = ^i_m_data[23:16];
   assign nwords    = NW'(count_q == 8'd0 ? 256 : int'(count_q)) * NW'(SECTOR_WORDS);
   assign wr_class  = cmd_q inside {8'hCA, 8'h35, 8'h3D, 8'h30, 8'h34};
   assign tx_phase  = state_q inside {CMD, DHDR, DATA};
   // a pending abort drops valid immediately so no further word slips out
   assign o_s_valid = (tx_phase && !i_abort && (state_q != DATA || i_wr_valid)) || state_q == ABRT;
   assign tx_go     = tx_phase && o_s_valid && !i_s_full;
   assign o_wr_ready = state_q == DATA && !i_s_full && !i_abort;
   assign o_s_data  = state_q == CMD  ? (widx_q == 2'd0 ? {8'h27, 8'h80, cmd_q, 8'h00} :
                                         widx_q == 2'd1 ? {8'h40 | {4'h0, lba_q[27:24]}, lba_q[23:0]} :
                                         widx_q == 2'd2 ? 32'h0 : {count_q, 24'h0}) :
                      state_q == DHDR ? 32'h4600_0000 :
                      state_q == DATA ? i_wr_data : 32'h0;
   assign o_s_last  = (state_q == CMD && widx_q == 2'd3) || (state_q == DATA && wcnt_q == nwords - NW'(1)) ||
                      state_q == ABRT;
   assign o_s_abort = state_q == ABRT;
   assign o_m_ready = state_q == WAIT_RSP;
   assign rx_go     = o_m_ready && i_m_valid;
   assign rx_good   = i_m_data[31:24] == 8'h34;
   assign o_req_ready = state_q == IDLE;
   assign o_done    = state_q == DONE;
   assign o_err     = o_done && (status_q[0] || error_q != 8'd0 || timeout_q || abort_q);
   assign o_timeout = o_done && timeout_q;
   assign o_status  = status_q;
   assign o_error   = error_q;
   always_comb begin
      state_d   = state_q;
      cmd_d     = cmd_q;
      lba_d     = lba_q;
      count_d   = count_q;
      status_d  = status_q;
      error_d   = error_q;
      widx_d    = widx_q;
      wcnt_d    = wcnt_q;
      tcnt_d    = tcnt_q;
      timeout_d = timeout_q;
      abort_d   = abort_q;
      inframe_d = inframe_q;
      good_d    = good_q;
      case (state_q)
         IDLE: if (i_req_valid) begin
            state_d   = CMD;
            cmd_d     = i_req_cmd;
            lba_d     = i_req_lba;
            count_d   = i_req_count;
            status_d  = 8'd0;
            error_d   = 8'd0;
            timeout_d = 1'b0;
            abort_d   = 1'b0;
            widx_d    = 2'd0;
            wcnt_d    = '0;
            tcnt_d    = '0;
            inframe_d = 1'b0;
            good_d    = 1'b0;
         end
         CMD: if (i_abort) begin
            state_d = ABRT;
            abort_d = 1'b1;
         end else if (tx_go) begin
            widx_d  = widx_q + 2'd1;
            state_d = widx_q == 2'd3 ? (wr_class ? DHDR : WAIT_RSP) : CMD;
         end
         DHDR: if (i_abort) begin
            state_d = ABRT;
            abort_d = 1'b1;
         end else if (tx_go) state_d = DATA;
         DATA: if (i_abort) begin
            state_d = ABRT;
            abort_d = 1'b1;
         end else if (tx_go) begin
            wcnt_d  = wcnt_q + NW'(1);
            state_d = o_s_last ? WAIT_RSP : DATA;
         end
         ABRT: state_d = DONE;
         WAIT_RSP: if (i_abort) begin
            state_d = DONE;
            abort_d = 1'b1;
         end else if (rx_go) begin
            tcnt_d = '0;
            if (!inframe_q) begin
               good_d   = rx_good;
               status_d = rx_good ? i_m_data[15:8] : status_q;
               error_d  = rx_good ? i_m_data[7:0] : error_q;
            end
            inframe_d = !i_m_last;
            state_d   = (i_m_last && (inframe_q ? good_q : rx_good)) ? DONE : WAIT_RSP;
         end else begin
            tcnt_d = tcnt_q + LGTIMEOUT'(1);
            if (tcnt_d == LGTIMEOUT'(TIMEOUT_CYCLES)) begin
               state_d   = DONE;
               timeout_d = 1'b1;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge i_tx_clk) begin
      if (i_reset) begin
         state_q   <= IDLE;
         cmd_q     <= 8'd0;
         lba_q     <= 28'd0;
         count_q   <= 8'd0;
         status_q  <= 8'd0;
         error_q   <= 8'd0;
         widx_q    <= 2'd0;
         wcnt_q    <= '0;
         tcnt_q    <= '0;
         timeout_q <= 1'b0;
         abort_q   <= 1'b0;
         inframe_q <= 1'b0;
         good_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cmd_q     <= cmd_d;
         lba_q     <= lba_d;
         count_q   <= count_d;
         status_q  <= status_d;
         error_q   <= error_d;
         widx_q    <= widx_d;
         wcnt_q    <= wcnt_d;
         tcnt_q    <= tcnt_d;
         timeout_q <= timeout_d;
         abort_q   <= abort_d;
         inframe_q <= inframe_d;
         good_q    <= good_d;
      end
   end
endmodule

// File: tb/tb_sata_cmd_sequencer.sv
// tb_sata_cmd_sequencer: directed stimulus with a TX-word and completion scoreboard
module tb_sata_cmd_sequencer;
   localparam int TMO = 20;
   logic        i_tx_clk = 1'b0, i_reset = 1'b1;
   logic        i_req_valid = 1'b0, i_abort = 1'b0, i_wr_valid = 1'b0, i_s_full = 1'b0;
   logic        i_m_valid = 1'b0, i_m_last = 1'b0;
   logic [7:0]  i_req_cmd = 8'd0, i_req_count = 8'd0;
   logic [27:0] i_req_lba = 28'd0;
   logic [31:0] i_wr_data = 32'd0, i_m_data = 32'd0;
   logic        o_req_ready, o_wr_ready, o_s_valid, o_s_last, o_s_abort, o_m_ready;
   logic        o_done, o_err, o_timeout;
   logic [31:0] o_s_data;
   logic [7:0]  o_status, o_error;
   logic [33:0] tx_q[$];
   logic [17:0] done_q[$];
   int          tests = 0, fails = 0;

   sata_cmd_sequencer #(.SECTOR_WORDS(4), .TIMEOUT_CYCLES(TMO), .LGTIMEOUT(5)) dut (
      .i_tx_clk(i_tx_clk), .i_reset(i_reset),
      .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_cmd(i_req_cmd),
      .i_req_lba(i_req_lba), .i_req_count(i_req_count), .i_abort(i_abort),
      .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready), .i_wr_data(i_wr_data),
      .o_s_valid(o_s_valid), .i_s_full(i_s_full), .o_s_data(o_s_data), .o_s_last(o_s_last),
      .o_s_abort(o_s_abort), .i_m_valid(i_m_valid), .o_m_ready(o_m_ready), .i_m_data(i_m_data),
      .i_m_last(i_m_last), .o_done(o_done), .o_err(o_err), .o_timeout(o_timeout),
      .o_status(o_status), .o_error(o_error)
   );

   always #5 i_tx_clk = ~i_tx_clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      tests++;
      fails++;
      $display("FAIL %s: got event expected none", name);
   endtask

   // monitor: every transferred TX word and every completion is popped from the scoreboard
   always @(negedge i_tx_clk) begin
      if (!i_reset) begin
         if (o_s_valid && (!i_s_full || o_s_abort)) begin
            if (tx_q.size() == 0) fail_now("tx_unexpected");
            else check("tx_word", {o_s_abort, o_s_last, o_s_data}, tx_q.pop_front());
         end
         if (o_done) begin
            if (done_q.size() == 0) fail_now("done_unexpected");
            else check("done", {o_err, o_timeout, o_status, o_error}, done_q.pop_front());
         end
      end
   end

   task automatic exp_tx(input logic ab, input logic last, input logic [31:0] d);
      tx_q.push_back({ab, last, d});
   endtask

   task automatic exp_done(input logic err, input logic tmo, input logic [7:0] st, input logic [7:0] er);
      done_q.push_back({err, tmo, st, er});
   endtask

   task automatic issue(input logic [7:0] cmd, input logic [27:0] lba, input logic [7:0] cnt);
      int n = 0;
      @(negedge i_tx_clk);
      while (!o_req_ready && n < 200) begin
         @(negedge i_tx_clk);
         n++;
      end
      check("req_ready", o_req_ready, 1);
      i_req_valid = 1'b1;
      i_req_cmd   = cmd;
      i_req_lba   = lba;
      i_req_count = cnt;
      @(posedge i_tx_clk);
      #1 i_req_valid = 1'b0;
   endtask

   task automatic send_data(input logic [31:0] d);
      int n = 0;
      i_wr_valid = 1'b1;
      i_wr_data  = d;
      @(negedge i_tx_clk);
      while (!o_wr_ready && n < 200) begin
         @(negedge i_tx_clk);
         n++;
      end
      if (n >= 200) fail_now("wr_ready_timeout");
      @(posedge i_tx_clk);
      #1 i_wr_valid = 1'b0;
   endtask

   task automatic bubble();
      i_wr_valid = 1'b0;
      @(negedge i_tx_clk);
      check("bubble_hole", o_s_valid, 0);
      @(posedge i_tx_clk);
      #1;
   endtask

   task automatic rx_word(input logic [31:0] d, input logic last);
      int n = 0;
      i_m_valid = 1'b1;
      i_m_data  = d;
      i_m_last  = last;
      @(negedge i_tx_clk);
      while (!o_m_ready && n < 200) begin
         @(negedge i_tx_clk);
         n++;
      end
      if (n >= 200) fail_now("m_ready_timeout");
      @(posedge i_tx_clk);
      #1 i_m_valid = 1'b0;
      i_m_last = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      @(negedge i_tx_clk);
      while (!o_done && n < 200) begin
         @(negedge i_tx_clk);
         n++;
      end
      check("done_seen", o_done, 1);
      @(posedge i_tx_clk);
      #1;
   endtask

   initial begin
      int cyc, n;
      repeat (3) @(posedge i_tx_clk);
      #1 i_reset = 1'b0;
      @(negedge i_tx_clk);
      check("rst_ready", o_req_ready, 1);
      check("rst_stream", {o_s_valid, o_s_last, o_s_abort, o_wr_ready, o_m_ready}, 0);
      check("rst_done", {o_done, o_err, o_timeout, o_status, o_error}, 0);

      // non-data command, single-word D2H with status bit 0 set
      exp_tx(0, 0, 32'h2780_E700);
      exp_tx(0, 0, 32'h4000_0000);
      exp_tx(0, 0, 32'h0000_0000);
      exp_tx(0, 1, 32'h0000_0000);
      issue(8'hE7, 28'h0, 8'h00);
      exp_done(1, 0, 8'h77, 8'h00);
      rx_word(32'h3400_7700, 1);
      wait_done();
      @(negedge i_tx_clk);
      check("status_hold", o_status, 8'h77);

      // write DMA, 2 sectors of 4 words, with three source bubbles
      exp_tx(0, 0, 32'h2780_CA00);
      exp_tx(0, 0, 32'h4000_0012);
      exp_tx(0, 0, 32'h0000_0000);
      exp_tx(0, 1, 32'h0200_0000);
      exp_tx(0, 0, 32'h4600_0000);
      for (int k = 0; k < 8; k++) exp_tx(0, k == 7, 32'hA5A5_0000 + k);
      issue(8'hCA, 28'h000_0012, 8'd2);
      @(negedge i_tx_clk);
      check("status_clear", o_status, 8'h00);
      for (int k = 0; k < 8; k++) begin
         if (k == 2 || k == 4 || k == 6) bubble();
         send_data(32'hA5A5_0000 + k);
      end
      exp_done(1, 0, 8'h50, 8'h04);
      rx_word(32'h3400_5004, 1);
      wait_done();

      // read DMA under toggling backpressure; non-D2H frame is skipped
      exp_tx(0, 0, 32'h2780_C800);
      exp_tx(0, 0, 32'h40AB_CDEF);
      exp_tx(0, 0, 32'h0000_0000);
      exp_tx(0, 1, 32'h0100_0000);
      fork
         issue(8'hC8, 28'h0AB_CDEF, 8'd1);
         for (int k = 0; k < 20; k++) begin
            i_s_full = k[1];
            @(posedge i_tx_clk);
            #1;
         end
      join
      i_s_full = 1'b0;
      check("rd_cmd_words", tx_q.size(), 0);
      rx_word(32'h4600_0000, 0);
      rx_word(32'h1111_1111, 0);
      rx_word(32'h2222_2222, 1);
      exp_done(0, 0, 8'h50, 8'h00);
      rx_word(32'h3400_5000, 0);
      rx_word(32'h0000_0000, 1);
      wait_done();

      // no response: timeout at exactly TMO cycles of waiting
      exp_tx(0, 0, 32'h2780_EC00);
      exp_tx(0, 0, 32'h4123_4567);
      exp_tx(0, 0, 32'h0000_0000);
      exp_tx(0, 1, 32'h0100_0000);
      issue(8'hEC, 28'h123_4567, 8'd1);
      exp_done(1, 1, 8'h00, 8'h00);
      n = 0;
      @(negedge i_tx_clk);
      while (!o_m_ready && n < 200) begin
         @(negedge i_tx_clk);
         n++;
      end
      cyc = 0;
      while (o_m_ready && cyc < 200) begin
         cyc++;
         @(negedge i_tx_clk);
      end
      check("timeout_cycles", cyc, TMO);
      check("timeout_done", o_done, 1);

      // next request presented during DONE is taken the cycle after
      exp_tx(0, 0, 32'h2780_3500);
      exp_tx(0, 0, 32'h4000_0100);
      exp_tx(0, 0, 32'h0000_0000);
      exp_tx(0, 1, 32'h0100_0000);
      exp_tx(0, 0, 32'h4600_0000);
      exp_tx(0, 0, 32'hC0DE_0000);
      exp_tx(0, 0, 32'hC0DE_0001);
      exp_tx(1, 1, 32'h0000_0000);
      i_req_valid = 1'b1;
      i_req_cmd   = 8'h35;
      i_req_lba   = 28'h000_0100;
      i_req_count = 8'd1;
      @(posedge i_tx_clk);
      #1;
      @(negedge i_tx_clk);
      check("ready_after_done", o_req_ready, 1);
      @(posedge i_tx_clk);
      #1 i_req_valid = 1'b0;
      @(negedge i_tx_clk);
      check("accepted", o_req_ready, 0);

      // abort while the third data word is offered
      send_data(32'hC0DE_0000);
      send_data(32'hC0DE_0001);
      i_wr_valid = 1'b1;
      i_wr_data  = 32'hC0DE_0002;
      i_abort    = 1'b1;
      @(negedge i_tx_clk);
      check("abort_drop", {o_s_valid, o_wr_ready}, 0);
      @(posedge i_tx_clk);
      #1 i_abort = 1'b0;
      i_wr_valid = 1'b0;
      exp_done(1, 0, 8'h00, 8'h00);
      wait_done();

      // reset while word1 of the command is stalled
      exp_tx(0, 0, 32'h2780_E700);
      issue(8'hE7, 28'h0, 8'h00);
      @(posedge i_tx_clk);
      #1 i_s_full = 1'b1;
      i_reset = 1'b1;
      @(posedge i_tx_clk);
      #1 i_reset = 1'b0;
      i_s_full = 1'b0;
      @(negedge i_tx_clk);
      check("rst_mid_ready", o_req_ready, 1);
      check("rst_mid_out", {o_s_valid, o_s_last, o_done, o_m_ready}, 0);

      check("tx_q_empty", tx_q.size(), 0);
      check("done_q_empty", done_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/sata_cmd_sequencer.md
Name: sata_cmd_sequencer

Overview:
- Host-side sequencer that turns one ATA command request into SATA frames on the transport TX stream.
- Builds a 4-word H2D Register FIS, a Data FIS for DMA write commands, and a Data FIS for PIO write commands.
- Then waits for the D2H Register FIS response and reports status, error and timeout to the command issuer.
- Sits between the command/register front end and the SATA command/transport layer (the mdl_satacmd model in simulation).
- Serialises commands: only one command is outstanding at a time.

Parameters:
- SECTOR_WORDS, 4: 32-bit words per sector; 4 for simulation, 128 for real 512-byte sectors.
- TIMEOUT_CYCLES, 4096: i_tx_clk cycles allowed in WAIT_RSP with no response word before a timeout.
- LGTIMEOUT, 13: width of the timeout counter; must satisfy 2^LGTIMEOUT > TIMEOUT_CYCLES.

Ports:
- i_tx_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_req_valid  in  1  command request
- o_req_ready  out  1  high only in IDLE
- i_req_cmd  in  8  ATA command code
- i_req_lba  in  28  28-bit LBA
- i_req_count  in  8  sector count; 0 means 256
- i_abort  in  1  abort the command in flight
- i_wr_valid  in  1  write-data word available
- o_wr_ready  out  1  write-data word consumed
- i_wr_data  in  32  write-data word
- o_s_valid  out  1  TX stream valid
- i_s_full  in  1  TX backpressure; a word transfers when o_s_valid && !i_s_full
- o_s_data  out  32  TX word
- o_s_last  out  1  last word of the FIS
- o_s_abort  out  1  frame abort
- i_m_valid  in  1  RX word valid
- o_m_ready  out  1  RX ready
- i_m_data  in  32  RX word
- i_m_last  in  1  last word of the RX frame
- o_done  out  1  one-cycle completion pulse
- o_err  out  1  valid with o_done
- o_timeout  out  1  valid with o_done
- o_status  out  8  D2H status, held until the next request is accepted
- o_error  out  8  D2H error, held until the next request is accepted

Behaviour:
- Reset: IDLE; all stream valids/last/abort, o_wr_ready, o_m_ready, o_done, o_err, o_timeout = 0; o_status = o_error = 0; o_req_ready = 1.
- Request accept: on i_req_valid && o_req_ready, latch cmd, lba and count; clear o_status, o_error, o_err, o_timeout; go to CMD next cycle.
- Write commands (write class): 0xCA, 0x35, 0x3D, 0x30, 0x34.
- Data length: nwords = (count==0 ? 256 : count) * SECTOR_WORDS, computed at 16 bits minimum.
- CMD: emit 4 words, each advancing only on transfer:
  - word0 = {8'h27, 8'h80, cmd, 8'h00}
  - word1 = {8'h40 | lba[27:24], lba[23:0]}
  - word2 = 32'h0
  - word3 = {count, 24'h0}, with o_s_last = 1
- After word3 transfers: go to DHDR if the command is write class, else WAIT_RSP.
- DHDR: emit 32'h46000000, o_s_last = 0, then go to DATA.
- DATA: pass data through with o_s_valid = i_wr_valid, o_wr_ready = !i_s_full, o_s_data = i_wr_data.
  - The word counter increments on each transfer.
  - o_s_last = 1 on word nwords; then go to WAIT_RSP.
  - i_wr_valid low produces stream bubbles, never a stall error.
- WAIT_RSP/RSP: o_m_ready = 1.
  - First RX word: if [31:24]==8'h34, latch status = [15:8] and error = [7:0] and mark the frame good; otherwise mark it bad.
  - A good frame ends on i_m_last: go to DONE. A bad frame is discarded on i_m_last and waiting continues.
  - A 1-word frame that is also last is handled in the same cycle.
- Timeout: the counter runs only in WAIT_RSP, clears on any RX handshake, and reaching TIMEOUT_CYCLES goes to DONE with o_timeout = 1 and o_err = 1.
- DONE: one-cycle state; o_done = 1, o_err = (status[0] | error != 0 | timeout); then IDLE. Requests are not accepted during DONE.
- Abort in CMD/DHDR/DATA: drop valid; pulse o_s_abort for 1 cycle with o_s_last = 1 and o_s_valid = 1, data 0; then DONE with o_err = 1. Abort in WAIT_RSP: DONE with o_err = 1. i_abort is ignored in IDLE/DONE.
- i_s_full held high: words and counters freeze and o_s_data stays stable; the timeout counter does not run.
- Reset mid-operation: the frame is truncated with no o_s_last or o_done; everything returns to the reset values.

Test Plan:
- Non-data command 0xE7, LBA 0, count 0, i_s_full = 0 -> TX words 27_80_E7_00, 40_000000, 0, 00_000000 (last on the 4th) -> model response with status 0x77 -> o_done, o_status = 0x77, o_err = 1.
- Write DMA 0xCA, LBA 0x0000012, count 2, SECTOR_WORDS = 4 -> 4 command words, then 46000000, then 8 data words with o_s_last only on the 8th; the data bench inserts 3 bubbles that must appear as stream holes.
- Read DMA 0xC8 with i_s_full toggled every 2 cycles -> word order and content unchanged, no duplicated or dropped words, o_s_last only on word3.
- RX frame with first word 0x46000000 followed by a D2H frame with status 0x50, error 0 -> the first frame is ignored, o_status = 0x50, o_err = 0.
- No response for TIMEOUT_CYCLES -> o_done with o_timeout = 1 and o_err = 1 at exactly the limit; the next request is accepted the following cycle.
- i_abort during DATA word 3 -> one-cycle o_s_abort, no further words, o_done with o_err = 1; reset during CMD word1 -> idle with o_req_ready = 1 next cycle.
